// File: rtl/zda_frame_tx.sv
// zda_frame_tx: PPS-triggered ZDA time sentence transmitter.
// Each PPS rising edge latches the BCD time and date and emits
// "$GPZDA,hhmmss.00,dd,mm,yyyy" followed by CR/LF, one byte per valid/ready
// transfer. Define CHECKSUM_EN to add "*HH" (XOR of bytes 1..26) before CR/LF.
module zda_frame_tx #(
  parameter logic [15:0] TALKER_ID  = 16'h4750,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pps,
  input  logic [7:0]  hour_bcd,
  input  logic [7:0]  min_bcd,
  input  logic [7:0]  sec_bcd,
  input  logic [7:0]  day_bcd,
  input  logic [7:0]  month_bcd,
  input  logic [15:0] year_bcd,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        frame_done,
  output logic        bcd_err,
  output logic        pps_overrun
);

`ifdef CHECKSUM_EN
  localparam logic [4:0] LAST_IDX = 5'd31;
`else
  localparam logic [4:0] LAST_IDX = 5'd28;
`endif

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } state_t;

  state_t      state_q, state_d;
  logic        pps_prev_q, pps_prev_d;
  logic [4:0]  idx_q, idx_d;
  logic [15:0] gap_cnt_q, gap_cnt_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d;
  logic        busy_q, busy_d;
  logic        frame_done_q, frame_done_d;
  logic        bcd_err_q, bcd_err_d;
  logic        pps_overrun_q, pps_overrun_d;
  logic        err_q, err_d;
  logic [7:0]  sh_hour_q, sh_hour_d;
  logic [7:0]  sh_min_q, sh_min_d;
  logic [7:0]  sh_sec_q, sh_sec_d;
  logic [7:0]  sh_day_q, sh_day_d;
  logic [7:0]  sh_month_q, sh_month_d;
  logic [15:0] sh_year_q, sh_year_d;
`ifdef CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  logic        rise;
  logic        xfer;
  logic [4:0]  load_idx;
  logic [7:0]  nxt_byte;
  logic        nxt_err;

  // BCD nibble to ASCII digit; out-of-range nibbles become '?' with error bit
  function automatic logic [8:0] bcd_char(input logic [3:0] n);
    if (n > 4'd9) begin
      return {1'b1, 8'h3F};
    end
    return {1'b0, 8'h30 + {4'h0, n}};
  endfunction

`ifdef CHECKSUM_EN
  // Nibble to uppercase hex ASCII
  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n > 4'd9) ? 8'h37 + {4'h0, n} : 8'h30 + {4'h0, n};
  endfunction
`endif

  assign rise     = pps & ~pps_prev_q;
  assign xfer     = tx_valid_q & tx_ready;
  // In SEND the byte being loaded follows the one just accepted; in GAP idx
  // has already advanced.
  assign load_idx = (state_q == SEND) ? idx_q + 5'd1 : idx_q;

  // Sentence byte mux indexed by the position being loaded
  always_comb begin
    {nxt_err, nxt_byte} = {1'b0, 8'h24};
    case (load_idx)
      5'd1:  {nxt_err, nxt_byte} = {1'b0, TALKER_ID[15:8]};
      5'd2:  {nxt_err, nxt_byte} = {1'b0, TALKER_ID[7:0]};
      5'd3:  {nxt_err, nxt_byte} = {1'b0, 8'h5A};
      5'd4:  {nxt_err, nxt_byte} = {1'b0, 8'h44};
      5'd5:  {nxt_err, nxt_byte} = {1'b0, 8'h41};
      5'd6:  {nxt_err, nxt_byte} = {1'b0, 8'h2C};
      5'd7:  {nxt_err, nxt_byte} = bcd_char(sh_hour_q[7:4]);
      5'd8:  {nxt_err, nxt_byte} = bcd_char(sh_hour_q[3:0]);
      5'd9:  {nxt_err, nxt_byte} = bcd_char(sh_min_q[7:4]);
      5'd10: {nxt_err, nxt_byte} = bcd_char(sh_min_q[3:0]);
      5'd11: {nxt_err, nxt_byte} = bcd_char(sh_sec_q[7:4]);
      5'd12: {nxt_err, nxt_byte} = bcd_char(sh_sec_q[3:0]);
      5'd13: {nxt_err, nxt_byte} = {1'b0, 8'h2E};
      5'd14: {nxt_err, nxt_byte} = {1'b0, 8'h30};
      5'd15: {nxt_err, nxt_byte} = {1'b0, 8'h30};
      5'd16: {nxt_err, nxt_byte} = {1'b0, 8'h2C};
      5'd17: {nxt_err, nxt_byte} = bcd_char(sh_day_q[7:4]);
      5'd18: {nxt_err, nxt_byte} = bcd_char(sh_day_q[3:0]);
      5'd19: {nxt_err, nxt_byte} = {1'b0, 8'h2C};
      5'd20: {nxt_err, nxt_byte} = bcd_char(sh_month_q[7:4]);
      5'd21: {nxt_err, nxt_byte} = bcd_char(sh_month_q[3:0]);
      5'd22: {nxt_err, nxt_byte} = {1'b0, 8'h2C};
      5'd23: {nxt_err, nxt_byte} = bcd_char(sh_year_q[15:12]);
      5'd24: {nxt_err, nxt_byte} = bcd_char(sh_year_q[11:8]);
      5'd25: {nxt_err, nxt_byte} = bcd_char(sh_year_q[7:4]);
      5'd26: {nxt_err, nxt_byte} = bcd_char(sh_year_q[3:0]);
`ifdef CHECKSUM_EN
      5'd27: {nxt_err, nxt_byte} = {1'b0, 8'h2A};
      5'd28: {nxt_err, nxt_byte} = {1'b0, hex_char(csum_q[7:4])};
      5'd29: {nxt_err, nxt_byte} = {1'b0, hex_char(csum_q[3:0])};
      5'd30: {nxt_err, nxt_byte} = {1'b0, 8'h0D};
      5'd31: {nxt_err, nxt_byte} = {1'b0, 8'h0A};
`else
      5'd27: {nxt_err, nxt_byte} = {1'b0, 8'h0D};
      5'd28: {nxt_err, nxt_byte} = {1'b0, 8'h0A};
`endif
      default: {nxt_err, nxt_byte} = {1'b0, 8'h24};
    endcase
  end

  // Frame sequencing: start on PPS edge, advance on each transfer, optional gap
  always_comb begin
    state_d       = state_q;
    pps_prev_d    = pps;
    idx_d         = idx_q;
    gap_cnt_d     = gap_cnt_q;
    tx_data_d     = tx_data_q;
    tx_valid_d    = tx_valid_q;
    busy_d        = busy_q;
    frame_done_d  = 1'b0;
    bcd_err_d     = 1'b0;
    pps_overrun_d = 1'b0;
    err_d         = err_q;
    sh_hour_d     = sh_hour_q;
    sh_min_d      = sh_min_q;
    sh_sec_d      = sh_sec_q;
    sh_day_d      = sh_day_q;
    sh_month_d    = sh_month_q;
    sh_year_d     = sh_year_q;
`ifdef CHECKSUM_EN
    csum_d        = csum_q;
`endif

    case (state_q)
      IDLE: begin
        if (rise) begin
          sh_hour_d  = hour_bcd;
          sh_min_d   = min_bcd;
          sh_sec_d   = sec_bcd;
          sh_day_d   = day_bcd;
          sh_month_d = month_bcd;
          sh_year_d  = year_bcd;
          err_d      = 1'b0;
`ifdef CHECKSUM_EN
          csum_d     = '0;
`endif
          idx_d      = '0;
          tx_data_d  = 8'h24;
          tx_valid_d = 1'b1;
          busy_d     = 1'b1;
          state_d    = SEND;
        end
      end

      SEND: begin
        pps_overrun_d = rise;
        if (xfer) begin
`ifdef CHECKSUM_EN
          if ((idx_q >= 5'd1) && (idx_q <= 5'd26)) begin
            csum_d = csum_q ^ tx_data_q;
          end
`endif
          if (idx_q == LAST_IDX) begin
            frame_done_d = 1'b1;
            bcd_err_d    = err_q;
            tx_valid_d   = 1'b0;
            busy_d       = 1'b0;
            idx_d        = '0;
            state_d      = IDLE;
          end else begin
            idx_d = idx_q + 5'd1;
            if (GAP_CYCLES == 0) begin
              tx_data_d = nxt_byte;
              err_d     = err_q | nxt_err;
            end else begin
              tx_valid_d = 1'b0;
              gap_cnt_d  = 16'(GAP_CYCLES - 1);
              state_d    = GAP;
            end
          end
        end
      end

      GAP: begin
        pps_overrun_d = rise;
        if (gap_cnt_q == '0) begin
          tx_data_d  = nxt_byte;
          err_d      = err_q | nxt_err;
          tx_valid_d = 1'b1;
          state_d    = SEND;
        end else begin
          gap_cnt_d = gap_cnt_q - 16'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      pps_prev_q    <= 1'b0;
      idx_q         <= '0;
      gap_cnt_q     <= '0;
      tx_data_q     <= '0;
      tx_valid_q    <= 1'b0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      bcd_err_q     <= 1'b0;
      pps_overrun_q <= 1'b0;
      err_q         <= 1'b0;
      sh_hour_q     <= '0;
      sh_min_q      <= '0;
      sh_sec_q      <= '0;
      sh_day_q      <= '0;
      sh_month_q    <= '0;
      sh_year_q     <= '0;
`ifdef CHECKSUM_EN
      csum_q        <= '0;
`endif
    end else begin
      state_q       <= state_d;
      pps_prev_q    <= pps_prev_d;
      idx_q         <= idx_d;
      gap_cnt_q     <= gap_cnt_d;
      tx_data_q     <= tx_data_d;
      tx_valid_q    <= tx_valid_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
      bcd_err_q     <= bcd_err_d;
      pps_overrun_q <= pps_overrun_d;
      err_q         <= err_d;
      sh_hour_q     <= sh_hour_d;
      sh_min_q      <= sh_min_d;
      sh_sec_q      <= sh_sec_d;
      sh_day_q      <= sh_day_d;
      sh_month_q    <= sh_month_d;
      sh_year_q     <= sh_year_d;
`ifdef CHECKSUM_EN
      csum_q        <= csum_d;
`endif
    end
  end

  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign bcd_err     = bcd_err_q;
  assign pps_overrun = pps_overrun_q;

endmodule

// File: tb/tb_zda_frame_tx.sv
// Testbench for zda_frame_tx: scoreboard of expected sentence bytes per frame,
// one back-to-back instance and one instance with a two-cycle inter-byte gap.
module tb_zda_frame_tx;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, pps, pps_g, ready0, ready1;
  logic [7:0]  hour, minute, sec, day, month;
  logic [15:0] year;
  logic [7:0]  data0, data1;
  logic        valid0, valid1, busy0, busy1, done0, done1;
  logic        err0, err1, ovr0, ovr1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic       e0[$];
  logic       e1[$];

  zda_frame_tx #(.TALKER_ID(16'h4750), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .pps(pps),
    .hour_bcd(hour), .min_bcd(minute), .sec_bcd(sec),
    .day_bcd(day), .month_bcd(month), .year_bcd(year),
    .tx_data(data0), .tx_valid(valid0), .tx_ready(ready0),
    .busy(busy0), .frame_done(done0), .bcd_err(err0), .pps_overrun(ovr0)
  );

  zda_frame_tx #(.TALKER_ID(16'h4750), .GAP_CYCLES(2)) dut1 (
    .clk(clk), .reset(reset), .pps(pps_g),
    .hour_bcd(hour), .min_bcd(minute), .sec_bcd(sec),
    .day_bcd(day), .month_bcd(month), .year_bcd(year),
    .tx_data(data1), .tx_valid(valid1), .tx_ready(ready1),
    .busy(busy1), .frame_done(done1), .bcd_err(err1), .pps_overrun(ovr1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] dg(input logic [3:0] n);
    return (n <= 4'd9) ? (8'h30 | {4'h0, n}) : 8'h3F;
  endfunction

`ifdef CHECKSUM_EN
  function automatic logic [7:0] hx(input logic [3:0] n);
    return (n <= 4'd9) ? (8'h30 | {4'h0, n}) : 8'h41 + {4'h0, n - 4'd10};
  endfunction
`endif

  // Build the expected sentence and push it onto the chosen DUT's scoreboard
  task automatic exp_frame(input int which, input logic [7:0] h, input logic [7:0] mi,
                           input logic [7:0] s, input logic [7:0] d, input logic [7:0] mo,
                           input logic [15:0] y);
    logic [7:0]  b[$];
    logic [55:0] all;
    logic        bad;
    b = '{8'h24, 8'h47, 8'h50, 8'h5A, 8'h44, 8'h41, 8'h2C};
    b.push_back(dg(h[7:4]));  b.push_back(dg(h[3:0]));
    b.push_back(dg(mi[7:4])); b.push_back(dg(mi[3:0]));
    b.push_back(dg(s[7:4]));  b.push_back(dg(s[3:0]));
    b.push_back(8'h2E); b.push_back(8'h30); b.push_back(8'h30); b.push_back(8'h2C);
    b.push_back(dg(d[7:4]));  b.push_back(dg(d[3:0]));  b.push_back(8'h2C);
    b.push_back(dg(mo[7:4])); b.push_back(dg(mo[3:0])); b.push_back(8'h2C);
    b.push_back(dg(y[15:12])); b.push_back(dg(y[11:8]));
    b.push_back(dg(y[7:4]));   b.push_back(dg(y[3:0]));
`ifdef CHECKSUM_EN
    begin
      logic [7:0] cs;
      cs = 8'h00;
      for (int i = 1; i <= 26; i++) cs = cs ^ b[i];
      b.push_back(8'h2A); b.push_back(hx(cs[7:4])); b.push_back(hx(cs[3:0]));
    end
`endif
    b.push_back(8'h0D); b.push_back(8'h0A);
    all = {h, mi, s, d, mo, y};
    bad = 1'b0;
    for (int i = 0; i < 14; i++) if (all[4*i +: 4] > 4'd9) bad = 1'b1;
    foreach (b[i]) begin
      if (which == 0) q0.push_back(b[i]);
      else            q1.push_back(b[i]);
    end
    if (which == 0) e0.push_back(bad);
    else            e1.push_back(bad);
  endtask

  // Scoreboard monitor for the back-to-back instance
  logic pend0 = 1'b0;
  int   ovr_cnt0 = 0;
  always @(negedge clk) begin
    if (reset) begin
      pend0 = 1'b0;
    end else begin
      if (pend0 || done0) begin
        chk("frame_done0", done0, pend0);
        if (done0) begin
          if (e0.size() > 0) chk("bcd_err0", err0, e0.pop_front());
          else               chk("bcd_err0_unexpected", 1, 0);
        end
      end
      pend0 = 1'b0;
      if (ovr0) ovr_cnt0++;
      if (valid0 && ready0) begin
        if (q0.size() == 0) chk("extra_byte0", 1, 0);
        else begin
          chk("byte0", data0, q0.pop_front());
          if (q0.size() == 0) pend0 = 1'b1;
        end
      end
    end
  end

  // Scoreboard and inter-byte gap monitor for the gapped instance
  logic pend1 = 1'b0;
  logic seen1 = 1'b0;
  int   low1 = 0;
  int   ovr_cnt1 = 0;
  always @(negedge clk) begin
    if (reset) begin
      pend1 = 1'b0;
      seen1 = 1'b0;
      low1  = 0;
    end else begin
      if (pend1 || done1) begin
        chk("frame_done1", done1, pend1);
        if (done1) begin
          seen1 = 1'b0;
          if (e1.size() > 0) chk("bcd_err1", err1, e1.pop_front());
          else               chk("bcd_err1_unexpected", 1, 0);
        end
      end
      pend1 = 1'b0;
      if (ovr1) ovr_cnt1++;
      if (valid1 && ready1) begin
        if (seen1) chk("gap_len1", low1, 2);
        low1  = 0;
        seen1 = 1'b1;
        if (q1.size() == 0) chk("extra_byte1", 1, 0);
        else begin
          chk("byte1", data1, q1.pop_front());
          if (q1.size() == 0) pend1 = 1'b1;
        end
      end else if (busy1) begin
        low1++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) until the scoreboard drains and the DUT is idle
  task automatic wait_done(input int which);
    int k;
    k = 0;
    while (k < 600 && !((which == 0) ? (q0.size() == 0 && !busy0)
                                     : (q1.size() == 0 && !busy1))) begin
      @(negedge clk);
      k++;
    end
    if (k >= 600) begin
      chk("timeout", 0, 1);
      q0.delete(); q1.delete(); e0.delete(); e1.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_byte0(input logic [7:0] b);
    for (int k = 0; k < 100; k++) begin
      if (valid0 && data0 == b) break;
      tick();
    end
  endtask

  task automatic set_time(input logic [7:0] h, input logic [7:0] mi, input logic [7:0] s,
                          input logic [7:0] d, input logic [7:0] mo, input logic [15:0] y);
    hour = h; minute = mi; sec = s; day = d; month = mo; year = y;
  endtask

  int base;

  initial begin
    reset = 1'b1; pps = 1'b0; pps_g = 1'b0; ready0 = 1'b1; ready1 = 1'b1;
    set_time(8'h12, 8'h34, 8'h56, 8'h19, 8'h07, 16'h2024);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", valid0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_data", data0, 0);
    chk("rst_done", done0, 0);
    chk("rst_err", err0, 0);
    chk("rst_ovr", ovr0, 0);
    @(posedge clk); #1 reset = 1'b0;
    tick();

    // Clean frame, pps held high throughout (single frame expected)
    base = ovr_cnt0;
    exp_frame(0, 8'h12, 8'h34, 8'h56, 8'h19, 8'h07, 16'h2024);
    pps = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("lat_valid", valid0, 1);
    chk("lat_data", data0, 8'h24);
    chk("lat_busy", busy0, 1);
    wait_done(0);
    repeat (5) tick();
    chk("held_pps_idle", busy0, 0);
    chk("held_pps_no_ovr", ovr_cnt0 - base, 0);
    pps = 1'b0;
    tick();

    // Backpressure at idx 7 (hour tens '1')
    exp_frame(0, 8'h12, 8'h34, 8'h56, 8'h19, 8'h07, 16'h2024);
    pps = 1'b1; tick(); pps = 1'b0;
    wait_byte0(8'h31);
    ready0 = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", valid0, 1);
      chk("bp_data", data0, 8'h31);
      @(posedge clk); #1;
    end
    ready0 = 1'b1;
    wait_done(0);

    // Overrun: second pps edge at byte 10 with a different hour
    base = ovr_cnt0;
    exp_frame(0, 8'h12, 8'h34, 8'h56, 8'h19, 8'h07, 16'h2024);
    pps = 1'b1; tick(); pps = 1'b0;
    wait_byte0(8'h34);
    hour = 8'h05;
    pps = 1'b1; tick(); tick(); pps = 1'b0;
    wait_done(0);
    chk("overrun_count", ovr_cnt0 - base, 1);
    hour = 8'h12;

    // Invalid BCD hour
    set_time(8'h1A, 8'h34, 8'h56, 8'h19, 8'h07, 16'h2024);
    exp_frame(0, 8'h1A, 8'h34, 8'h56, 8'h19, 8'h07, 16'h2024);
    pps = 1'b1; tick(); pps = 1'b0;
    wait_done(0);

    // Reset mid-frame at idx 10, then a fresh frame
    set_time(8'h12, 8'h34, 8'h56, 8'h19, 8'h07, 16'h2024);
    exp_frame(0, 8'h12, 8'h34, 8'h56, 8'h19, 8'h07, 16'h2024);
    pps = 1'b1; tick(); pps = 1'b0;
    wait_byte0(8'h34);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_valid", valid0, 0);
    chk("midrst_busy", busy0, 0);
    chk("midrst_done", done0, 0);
    q0.delete(); e0.delete();
    @(posedge clk); #1 reset = 1'b0;
    tick();
    set_time(8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 16'h2000);
    exp_frame(0, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 16'h2000);
    pps = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("fresh_valid", valid0, 1);
    chk("fresh_data", data0, 8'h24);
    wait_done(0);
    pps = 1'b0;
    tick();

    // Gapped instance: two idle cycles between bytes
    set_time(8'h21, 8'h09, 8'h07, 8'h28, 8'h02, 16'h2031);
    exp_frame(1, 8'h21, 8'h09, 8'h07, 8'h28, 8'h02, 16'h2031);
    pps_g = 1'b1; tick(); pps_g = 1'b0;
    wait_done(1);
    chk("gap_no_ovr", ovr_cnt1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/zda_frame_tx.md
Name: zda_frame_tx

Overview:
- PPS-triggered transmitter for the ASCII time sentence that the time-receive path parses.
- On each PPS rising edge it latches UTC time and date (BCD) and emits one ZDA sentence: "$GPZDA,hhmmss.00,dd,mm,yyyy" followed by an optional checksum and CR/LF.
- Output is byte-wide with a valid/ready handshake toward a UART transmitter.
- Field byte offsets: hh at 7-8, mm at 9-10, ss at 11-12, dd at 17-18, month at 20-21, yyyy at 23-26.

Parameters:
- TALKER_ID, 16'h4750 ("GP"): bytes 1-2 of the sentence.
- GAP_CYCLES, 0: idle cycles with tx_valid low after each accepted byte. 0 means back-to-back bytes.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- pps  in  1  pulse-per-second, synchronous to clk, level input
- hour_bcd  in  8  UTC hour, BCD
- min_bcd  in  8  minute, BCD
- sec_bcd  in  8  second, BCD
- day_bcd  in  8  day of month, BCD
- month_bcd  in  8  month, BCD
- year_bcd  in  16  4-digit year, BCD
- tx_data  out  8  ASCII byte
- tx_valid  out  1  tx_data is valid
- tx_ready  in  1  sink accepts the byte
- busy  out  1  a frame is in progress
- frame_done  out  1  one-cycle pulse when the last byte is accepted
- bcd_err  out  1  frame contained a nibble >9; valid only while frame_done is high
- pps_overrun  out  1  one-cycle pulse when a PPS edge arrives while busy

Behaviour:
- Reset: all outputs 0; state IDLE; pps_prev 0; byte index 0. Reset mid-frame aborts the frame: tx_valid is 0 the cycle after reset is sampled, with no frame_done.
- Edge detect: pps_prev is registered; rise = pps & ~pps_prev.
- State IDLE: on a clock edge with rise=1:
  - latch all BCD inputs into a shadow register;
  - clear the error flag and the checksum accumulator;
  - idx <= 0, tx_data <= 0x24 ('$'), tx_valid <= 1, busy <= 1;
  - go to SEND.
  - Latency: tx_valid is high in the first cycle after pps is sampled high.
- State SEND:
  - A byte transfers when tx_valid & tx_ready.
  - tx_data and tx_valid must stay stable until the transfer.
  - After a transfer: idx increments. tx_valid drops for GAP_CYCLES cycles (gap counter), then reasserts with the byte at the new idx. With GAP_CYCLES=0, tx_valid stays high and tx_data updates on the next edge.
- State DONE: on transfer of the last byte:
  - frame_done pulses and bcd_err shows the sticky flag, both on the edge after that transfer;
  - busy <= 0, tx_valid <= 0;
  - return to IDLE.
- Byte generation: a combinational mux on idx driven from the shadow register.
  - Fixed characters: "GPZDA," (talker from TALKER_ID), ".00,", and ','.
  - Digit bytes: 0x30 + nibble when nibble ≤ 9. Otherwise emit 0x3F ('?') and set the sticky error flag.
- Frame length: 29 bytes without the checksum (idx 0..28), ending 0x0D 0x0A.
- pps rise while busy or in a gap: ignored for frame control; the shadow register is unchanged; pps_overrun pulses for 1 cycle.
- pps held high: generates only one frame (edge-triggered).
- Input changes after latch have no effect on the current frame.

Optional Feature:
- CHECKSUM_EN defined:
  - Running XOR over accepted bytes idx 1..26.
  - After byte 26, emit '*' (0x2A), then the checksum as two uppercase hex ASCII characters (high nibble first), then 0x0D 0x0A.
  - Frame length is 32 bytes.
- CHECKSUM_EN undefined: no checksum logic; frame is 29 bytes.

Test Plan:
- Clean frame, no backpressure: inputs 12:34:56, 19/07/2024, tx_ready=1, GAP_CYCLES=0, no checksum -> 29 consecutive bytes "$GPZDA,123456.00,19,07,2024\r\n"; frame_done on the final transfer; bcd_err=0.
- Checksum: CHECKSUM_EN defined, inputs 00:00:00, 01/01/2000 -> bytes "$GPZDA,000000.00,01,01,2000*64\r\n" (32 bytes).
- Backpressure: tx_ready low for 5 cycles while idx=7 (hour tens '1') -> tx_data holds 0x31 with tx_valid=1; no byte dropped or duplicated; full frame still correct.
- Overrun: second pps rise at byte 10 with hour changed to 0x05 -> pps_overrun pulses once; frame still contains "12"; no restart.
- Invalid BCD: hour_bcd=8'h1A -> byte 8 = 0x3F; bcd_err=1 together with frame_done.
- Reset mid-frame: reset asserted at idx=10 -> tx_valid=0 and busy=0 next cycle; the next pps rise starts a fresh frame at '$'. Also run GAP_CYCLES=2 -> exactly 2 low-valid cycles between bytes.
